wb_retire_buf: RTL and testbench
================================

Name: wb_retire_buf

Overview:
Parametrised writeback/retire stage, successor to the single-entry WB stage. Accepts retiring instructions from MEM through the valid/allowin handshake and holds them in a DEPTH-entry in-order buffer. It retires one entry per cycle to the register-file write port and to the debug trace. Exceptions and ertn are reported at retire and flush the buffer. CSR access stays outside this block; it consumes wb_ex/wb_ecode/wb_pc/wb_vaddr/wb_ertn.

Parameters:
XLEN, 32, data/PC width
NREG, 32, GPR count; AW = $clog2(NREG)
DEPTH, 4, buffer entries; power of 2, >= 2
TRACE_STALL, 1, 1: retire waits for trace_ready; 0: trace_ready ignored

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
ms_to_ws_valid  in  1  MEM beat valid
ws_allowin  out  1  buffer accepts a beat this cycle
ms_pc  in  XLEN  instruction PC
ms_gr_we  in  1  writes GPR
ms_dest  in  AW  destination GPR
ms_result  in  XLEN  writeback data
ms_ex  in  1  instruction carries an exception
ms_ecode  in  6  exception code
ms_vaddr  in  XLEN  bad virtual address
ms_ertn  in  1  instruction is ertn
rf_we  out  1  GPR write enable
rf_waddr  out  AW  GPR write address
rf_wdata  out  XLEN  GPR write data
wb_ex  out  1  exception retired (1-cycle pulse)
wb_ecode  out  6  code of retired exception
wb_pc  out  XLEN  PC of head entry
wb_vaddr  out  XLEN  vaddr of head entry
wb_ertn  out  1  ertn retired (1-cycle pulse)
busy_mask  out  NREG  pending-write scoreboard for decode hazards
occupancy  out  $clog2(DEPTH+1)  valid entry count
trace_ready  in  1  trace consumer ready
debug_wb_pc  out  XLEN  trace PC
debug_wb_rf_we  out  4  trace write enable (replicated rf_we)
debug_wb_rf_wnum  out  AW  trace write register
debug_wb_rf_wdata  out  XLEN  trace write data

Behaviour:
- Reset (asynchronous, on reset=0): count, rd_ptr, wr_ptr and flush_hold clear immediately. All entry valid bits clear. All outputs read 0, including ws_allowin. Reset mid-operation discards every entry with no retire and no pulses.
- ws_allowin = reset & (count < DEPTH) & !flush_hold.
  - Depends only on registered state; there is no combinational path from trace_ready.
  - A full buffer refuses the beat even when a pop occurs in the same cycle.
- push = ms_to_ws_valid & ws_allowin. On push, {pc,gr_we,dest,result,ex,ecode,vaddr,ertn} is written at wr_ptr and wr_ptr advances mod DEPTH.
- fire = (count != 0) & (trace_ready | !TRACE_STALL).
- On fire, head entry H at rd_ptr retires combinationally in that cycle:
  - rf_we = fire & H.gr_we & !H.ex & !H.ertn; rf_waddr = H.dest; rf_wdata = H.result.
  - wb_ex = fire & H.ex.
  - wb_ertn = fire & H.ertn & !H.ex (ex has priority over ertn).
  - wb_ecode, wb_pc and wb_vaddr come from H; they are 0 when count == 0.
  - The debug_* outputs mirror rf_* and H.pc; debug_wb_rf_we = {4{rf_we}}.
  - If fire=0, all enables are 0 and the buffer holds.
- Normal retire (no ex/ertn): rd_ptr advances mod DEPTH. Next count = count + push - 1.
- Flush (wb_ex | wb_ertn): at the next edge, count=0, rd_ptr=wr_ptr=0, and all valid bits clear.
  - A beat pushed in the flush cycle is dropped.
  - flush_hold=1 for exactly one cycle, forcing ws_allowin=0; it clears on the following edge.
- busy_mask[d] = 1 iff some valid entry has gr_we & !ex & dest==d & d!=0. busy_mask[0] is always 0. It is recomputed from registered state, so a pushed entry appears the cycle after the push.
- occupancy = count (registered).
- Pointers wrap mod DEPTH. count saturates only via allowin, never exceeds DEPTH, and never underflows.

Test Plan:
- Fill: DEPTH=4, trace_ready=0, push 5 beats (pc 0x1c000000+4k) -> ws_allowin=0 after 4th push, occupancy=4, 5th beat held upstream; raise trace_ready -> 4 retires in order, rf_we each cycle, PCs ascending by 4.
- Scoreboard: push dest=5 gr_we=1, then dest=0 gr_we=1 -> busy_mask=0x00000020 one cycle after push; after retire busy_mask=0; rf_we for dest 0 still pulses with waddr=0.
- Exception flush: entries [A ok, B ex ecode=0x9 vaddr=0x1234, C ok] -> A writes rf; B gives wb_ex=1, wb_ecode=0x9, wb_vaddr=0x1234, rf_we=0; C never retires; next cycle occupancy=0, ws_allowin=0 for one cycle, then 1.
- ertn and priority: head with ertn=1 -> wb_ertn=1, wb_ex=0, rf_we=0, flush; head with ex=1 and ertn=1 -> wb_ex=1, wb_ertn=0.
- Simultaneous push/pop and wrap: trace_ready=1, continuous valid for 20 cycles -> occupancy stays 1, rd/wr pointers wrap, every beat retires exactly once in order; with TRACE_STALL=0 and trace_ready=0, same result.
- Async reset mid-run: assert reset=0 between clock edges with occupancy=3 -> outputs 0 immediately; after release, no retire of old entries, ws_allowin=1.

Source files
------------

// File: rtl/wb_retire_buf.sv
// -----------------------------------------------------------------------------
// wb_retire_buf
//
// Writeback / retire stage. Instructions arriving from MEM are held in an
// in-order buffer of DEPTH entries and retire one per cycle from the head
// entry. A retiring entry drives the register-file write port and the debug
// trace. An exception or ertn at the head is reported for one cycle and
// flushes the whole buffer. After a flush, the stage refuses new beats for
// one cycle.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   ms_to_ws_valid        MEM beat valid
//   ws_allowin            buffer accepts a beat this cycle
//   ms_*                  payload of the incoming beat (pc, gr_we, dest,
//                         result, ex, ecode, vaddr, ertn)
//   rf_we/waddr/wdata     GPR write port, driven by the retiring head
//   wb_ex/wb_ecode/wb_pc/wb_vaddr/wb_ertn
//                         exception / ertn report for the CSR block
//   busy_mask             GPRs with a pending write, for decode hazard checks
//   occupancy             number of valid entries
//   trace_ready           trace consumer ready (ignored when TRACE_STALL=0)
//   debug_wb_*            retire trace
// -----------------------------------------------------------------------------
module wb_retire_buf #(
    parameter int XLEN        = 32,
    parameter int NREG        = 32,
    parameter int DEPTH       = 4,
    parameter int TRACE_STALL = 1,
    localparam int AW = $clog2(NREG),
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ms_to_ws_valid,
    output logic            ws_allowin,
    input  logic [XLEN-1:0] ms_pc,
    input  logic            ms_gr_we,
    input  logic [AW-1:0]   ms_dest,
    input  logic [XLEN-1:0] ms_result,
    input  logic            ms_ex,
    input  logic [5:0]      ms_ecode,
    input  logic [XLEN-1:0] ms_vaddr,
    input  logic            ms_ertn,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            wb_ex,
    output logic [5:0]      wb_ecode,
    output logic [XLEN-1:0] wb_pc,
    output logic [XLEN-1:0] wb_vaddr,
    output logic            wb_ertn,
    output logic [NREG-1:0] busy_mask,
    output logic [CW-1:0]   occupancy,
    input  logic            trace_ready,
    output logic [XLEN-1:0] debug_wb_pc,
    output logic [3:0]      debug_wb_rf_we,
    output logic [AW-1:0]   debug_wb_rf_wnum,
    output logic [XLEN-1:0] debug_wb_rf_wdata
);

    localparam logic STALL_EN = (TRACE_STALL != 0);

    // Control state
    logic [CW-1:0]    count_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic             flush_hold_r;
    logic [DEPTH-1:0] valid_r;

    // Entry storage
    logic [XLEN-1:0]  pc_mem_r     [DEPTH];
    logic [DEPTH-1:0] gr_we_mem_r;
    logic [AW-1:0]    dest_mem_r   [DEPTH];
    logic [XLEN-1:0]  result_mem_r [DEPTH];
    logic [DEPTH-1:0] ex_mem_r;
    logic [5:0]       ecode_mem_r  [DEPTH];
    logic [XLEN-1:0]  vaddr_mem_r  [DEPTH];
    logic [DEPTH-1:0] ertn_mem_r;

    // Handshake and retire decode
    logic             allowin_s;
    logic             push_s;
    logic             has_head_s;
    logic             fire_s;
    logic             flush_s;
    logic             rf_we_s;
    logic             wb_ex_s;
    logic             wb_ertn_s;
    logic [XLEN-1:0]  hd_pc_s;
    logic             hd_gr_we_s;
    logic [AW-1:0]    hd_dest_s;
    logic [XLEN-1:0]  hd_result_s;
    logic             hd_ex_s;
    logic [5:0]       hd_ecode_s;
    logic [XLEN-1:0]  hd_vaddr_s;
    logic             hd_ertn_s;
    logic [NREG-1:0]  busy_s;

    // allowin is a function of registered state only (plus reset), so a pop
    // in the same cycle never opens a slot for a full buffer.
    assign allowin_s  = reset & (count_r < CW'(DEPTH)) & ~flush_hold_r;
    assign push_s     = ms_to_ws_valid & allowin_s;
    assign has_head_s = (count_r != {CW{1'b0}});
    assign fire_s     = has_head_s & (trace_ready | ~STALL_EN);

    // Head entry fields; forced to zero while the buffer is empty
    always_comb begin
        hd_pc_s     = {XLEN{1'b0}};
        hd_gr_we_s  = 1'b0;
        hd_dest_s   = {AW{1'b0}};
        hd_result_s = {XLEN{1'b0}};
        hd_ex_s     = 1'b0;
        hd_ecode_s  = 6'd0;
        hd_vaddr_s  = {XLEN{1'b0}};
        hd_ertn_s   = 1'b0;
        if (has_head_s) begin
            hd_pc_s     = pc_mem_r[rd_ptr_r];
            hd_gr_we_s  = gr_we_mem_r[rd_ptr_r];
            hd_dest_s   = dest_mem_r[rd_ptr_r];
            hd_result_s = result_mem_r[rd_ptr_r];
            hd_ex_s     = ex_mem_r[rd_ptr_r];
            hd_ecode_s  = ecode_mem_r[rd_ptr_r];
            hd_vaddr_s  = vaddr_mem_r[rd_ptr_r];
            hd_ertn_s   = ertn_mem_r[rd_ptr_r];
        end else begin
            hd_pc_s     = {XLEN{1'b0}};
            hd_gr_we_s  = 1'b0;
        end
    end

    // Exception wins over ertn; neither one writes the register file.
    assign rf_we_s   = fire_s & hd_gr_we_s & ~hd_ex_s & ~hd_ertn_s;
    assign wb_ex_s   = fire_s & hd_ex_s;
    assign wb_ertn_s = fire_s & hd_ertn_s & ~hd_ex_s;
    assign flush_s   = wb_ex_s | wb_ertn_s;

    // Pending-write scoreboard built from the stored entries; r0 never counts
    always_comb begin
        busy_s = {NREG{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            busy_s = busy_s |
                     ({{(NREG-1){1'b0}},
                       (valid_r[i] & gr_we_mem_r[i] & ~ex_mem_r[i] &
                        (dest_mem_r[i] != {AW{1'b0}}))} << dest_mem_r[i]);
        end
    end

    // Count, pointers, valid bits and the post-flush hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r      <= {CW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            flush_hold_r <= 1'b0;
            valid_r      <= {DEPTH{1'b0}};
        end else if (flush_s) begin
            // Everything in flight is discarded, including a same-cycle push.
            count_r      <= {CW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            flush_hold_r <= 1'b1;
            valid_r      <= {DEPTH{1'b0}};
        end else begin
            flush_hold_r <= 1'b0;
            count_r      <= count_r + CW'(push_s) - CW'(fire_s);
            if (fire_s) begin
                rd_ptr_r          <= rd_ptr_r + PW'(1);
                valid_r[rd_ptr_r] <= 1'b0;
            end
            // Push and pop never address the same slot: a pop needs a
            // non-empty buffer, a push needs a non-full one.
            if (push_s) begin
                wr_ptr_r          <= wr_ptr_r + PW'(1);
                valid_r[wr_ptr_r] <= 1'b1;
            end
        end
    end

    // Entry payload write on an accepted beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gr_we_mem_r <= {DEPTH{1'b0}};
            ex_mem_r    <= {DEPTH{1'b0}};
            ertn_mem_r  <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]     <= {XLEN{1'b0}};
                dest_mem_r[i]   <= {AW{1'b0}};
                result_mem_r[i] <= {XLEN{1'b0}};
                ecode_mem_r[i]  <= 6'd0;
                vaddr_mem_r[i]  <= {XLEN{1'b0}};
            end
        end else if (push_s && !flush_s) begin
            pc_mem_r[wr_ptr_r]     <= ms_pc;
            gr_we_mem_r[wr_ptr_r]  <= ms_gr_we;
            dest_mem_r[wr_ptr_r]   <= ms_dest;
            result_mem_r[wr_ptr_r] <= ms_result;
            ex_mem_r[wr_ptr_r]     <= ms_ex;
            ecode_mem_r[wr_ptr_r]  <= ms_ecode;
            vaddr_mem_r[wr_ptr_r]  <= ms_vaddr;
            ertn_mem_r[wr_ptr_r]   <= ms_ertn;
        end
    end

    assign ws_allowin        = allowin_s;
    assign rf_we             = rf_we_s;
    assign rf_waddr          = hd_dest_s;
    assign rf_wdata          = hd_result_s;
    assign wb_ex             = wb_ex_s;
    assign wb_ecode          = hd_ecode_s;
    assign wb_pc             = hd_pc_s;
    assign wb_vaddr          = hd_vaddr_s;
    assign wb_ertn           = wb_ertn_s;
    assign busy_mask         = busy_s;
    assign occupancy         = count_r;
    assign debug_wb_pc       = hd_pc_s;
    assign debug_wb_rf_we    = {4{rf_we_s}};
    assign debug_wb_rf_wnum  = hd_dest_s;
    assign debug_wb_rf_wdata = hd_result_s;

endmodule

// File: tb/tb_wb_retire_buf.sv
// -----------------------------------------------------------------------------
// tb_wb_retire_buf
//
// Two instances share one stimulus stream: A stalls on trace_ready, B ignores
// it. Each has a queue-based reference model; a compare process checks every
// output of both once per cycle, and directed phases add literal checks.
// -----------------------------------------------------------------------------
module tb_wb_retire_buf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ms_to_ws_valid = 1'b0;
    logic [31:0] ms_pc = 32'd0;
    logic        ms_gr_we = 1'b0;
    logic [4:0]  ms_dest = 5'd0;
    logic [31:0] ms_result = 32'd0;
    logic        ms_ex = 1'b0;
    logic [5:0]  ms_ecode = 6'd0;
    logic [31:0] ms_vaddr = 32'd0;
    logic        ms_ertn = 1'b0;
    logic        trace_ready = 1'b0;

    logic        a_allowin, a_rf_we, a_ex, a_ertn;
    logic [4:0]  a_waddr, a_dnum;
    logic [31:0] a_wdata, a_pc, a_va, a_busy, a_dpc, a_ddata;
    logic [5:0]  a_ec;
    logic [2:0]  a_occ;
    logic [3:0]  a_dwe;
    logic        b_allowin, b_rf_we, b_ex, b_ertn;
    logic [4:0]  b_waddr, b_dnum;
    logic [31:0] b_wdata, b_pc, b_va, b_busy, b_dpc, b_ddata;
    logic [5:0]  b_ec;
    logic [2:0]  b_occ;
    logic [3:0]  b_dwe;

    always #10 clk = ~clk;

    wb_retire_buf #(.XLEN(32), .NREG(32), .DEPTH(DEPTH), .TRACE_STALL(1)) u_a (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(a_allowin),
        .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
        .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_vaddr(ms_vaddr), .ms_ertn(ms_ertn),
        .rf_we(a_rf_we), .rf_waddr(a_waddr), .rf_wdata(a_wdata), .wb_ex(a_ex),
        .wb_ecode(a_ec), .wb_pc(a_pc), .wb_vaddr(a_va), .wb_ertn(a_ertn),
        .busy_mask(a_busy), .occupancy(a_occ), .trace_ready(trace_ready),
        .debug_wb_pc(a_dpc), .debug_wb_rf_we(a_dwe), .debug_wb_rf_wnum(a_dnum),
        .debug_wb_rf_wdata(a_ddata));

    wb_retire_buf #(.XLEN(32), .NREG(32), .DEPTH(DEPTH), .TRACE_STALL(0)) u_b (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(b_allowin),
        .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
        .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_vaddr(ms_vaddr), .ms_ertn(ms_ertn),
        .rf_we(b_rf_we), .rf_waddr(b_waddr), .rf_wdata(b_wdata), .wb_ex(b_ex),
        .wb_ecode(b_ec), .wb_pc(b_pc), .wb_vaddr(b_va), .wb_ertn(b_ertn),
        .busy_mask(b_busy), .occupancy(b_occ), .trace_ready(trace_ready),
        .debug_wb_pc(b_dpc), .debug_wb_rf_we(b_dwe), .debug_wb_rf_wnum(b_dnum),
        .debug_wb_rf_wdata(b_ddata));

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] res;
        logic        ex;
        logic [5:0]  ec;
        logic [31:0] va;
        logic        er;
    } ent_t;

    typedef struct packed {
        logic        allowin;
        logic        fire;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ex;
        logic [5:0]  ec;
        logic [31:0] pc;
        logic [31:0] va;
        logic        er;
        logic [31:0] busy;
        logic [2:0]  occ;
    } out_t;

    int   checks = 0;
    int   failures = 0;
    ent_t qa[$];
    ent_t qb[$];
    logic hold_a = 1'b0, hold_b = 1'b0;
    logic push_a = 1'b0, fire_a = 1'b0, flush_a = 1'b0;
    logic push_b = 1'b0, fire_b = 1'b0, flush_b = 1'b0;
    out_t ea, eb, aa, ab;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs straight from the retire rules: head of queue, size, hold flag
    function automatic out_t model_out(input ent_t q[$], input logic hold, input logic stall);
        out_t o;
        ent_t h;
        o = '0;
        o.allowin = reset && (q.size() < DEPTH) && !hold;
        o.occ = 3'(q.size());
        foreach (q[i])
            if (q[i].we && !q[i].ex && q[i].dest != 5'd0) o.busy[q[i].dest] = 1'b1;
        if (q.size() > 0) begin
            h       = q[0];
            o.fire  = trace_ready || !stall;
            o.pc    = h.pc;
            o.va    = h.va;
            o.ec    = h.ec;
            o.waddr = h.dest;
            o.wdata = h.res;
            o.rf_we = o.fire && h.we && !h.ex && !h.er;
            o.ex    = o.fire && h.ex;
            o.er    = o.fire && h.er && !h.ex;
        end
        return o;
    endfunction

    function automatic ent_t cur_ent();
        ent_t e;
        e.pc = ms_pc; e.we = ms_gr_we; e.dest = ms_dest; e.res = ms_result;
        e.ex = ms_ex; e.ec = ms_ecode; e.va = ms_vaddr; e.er = ms_ertn;
        return e;
    endfunction

    task automatic cmp_dut(input string t, input out_t e, input out_t a, input logic [31:0] dpc,
                           input logic [3:0] dwe, input logic [4:0] dnum, input logic [31:0] ddata);
        chk({t, ".allowin"}, a.allowin, e.allowin);
        chk({t, ".rf_we"}, a.rf_we, e.rf_we);
        chk({t, ".rf_waddr"}, a.waddr, e.waddr);
        chk({t, ".rf_wdata"}, a.wdata, e.wdata);
        chk({t, ".wb_ex"}, a.ex, e.ex);
        chk({t, ".wb_ecode"}, a.ec, e.ec);
        chk({t, ".wb_pc"}, a.pc, e.pc);
        chk({t, ".wb_vaddr"}, a.va, e.va);
        chk({t, ".wb_ertn"}, a.er, e.er);
        chk({t, ".busy_mask"}, a.busy, e.busy);
        chk({t, ".occupancy"}, a.occ, e.occ);
        chk({t, ".dbg_pc"}, dpc, e.pc);
        chk({t, ".dbg_we"}, dwe, {4{e.rf_we}});
        chk({t, ".dbg_wnum"}, dnum, e.waddr);
        chk({t, ".dbg_wdata"}, ddata, e.wdata);
    endtask

    // Compare process: mid low phase, inputs are stable until the next posedge
    always @(negedge clk) begin
        #5;
        ea = model_out(qa, hold_a, 1'b1);
        eb = model_out(qb, hold_b, 1'b0);
        aa = '0;
        aa.allowin = a_allowin; aa.rf_we = a_rf_we; aa.waddr = a_waddr; aa.wdata = a_wdata;
        aa.ex = a_ex; aa.ec = a_ec; aa.pc = a_pc; aa.va = a_va; aa.er = a_ertn;
        aa.busy = a_busy; aa.occ = a_occ;
        ab = '0;
        ab.allowin = b_allowin; ab.rf_we = b_rf_we; ab.waddr = b_waddr; ab.wdata = b_wdata;
        ab.ex = b_ex; ab.ec = b_ec; ab.pc = b_pc; ab.va = b_va; ab.er = b_ertn;
        ab.busy = b_busy; ab.occ = b_occ;
        cmp_dut("A", ea, aa, a_dpc, a_dwe, a_dnum, a_ddata);
        cmp_dut("B", eb, ab, b_dpc, b_dwe, b_dnum, b_ddata);
        push_a = ms_to_ws_valid && ea.allowin; fire_a = ea.fire; flush_a = ea.ex || ea.er;
        push_b = ms_to_ws_valid && eb.allowin; fire_b = eb.fire; flush_b = eb.ex || eb.er;
    end

    // Model state update on the clock, cleared immediately by reset
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            qa.delete(); qb.delete();
            hold_a <= 1'b0; hold_b <= 1'b0;
        end else begin
            if (flush_a) begin
                qa.delete(); hold_a <= 1'b1;
            end else begin
                hold_a <= 1'b0;
                if (fire_a) void'(qa.pop_front());
                if (push_a) qa.push_back(cur_ent());
            end
            if (flush_b) begin
                qb.delete(); hold_b <= 1'b1;
            end else begin
                hold_b <= 1'b0;
                if (fire_b) void'(qb.pop_front());
                if (push_b) qb.push_back(cur_ent());
            end
        end
    end

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic settle();
        #5;
    endtask

    task automatic beat(input logic [31:0] pc, input logic we, input logic [4:0] d,
                        input logic [31:0] r, input logic ex, input logic [5:0] ec,
                        input logic [31:0] va, input logic er);
        ms_to_ws_valid = 1'b1; ms_pc = pc; ms_gr_we = we; ms_dest = d; ms_result = r;
        ms_ex = ex; ms_ecode = ec; ms_vaddr = va; ms_ertn = er;
    endtask

    initial begin
        // Reset
        repeat (3) next();
        settle();
        chk("rst.allowin", a_allowin, 1'b0);
        chk("rst.occ", a_occ, 3'd0);
        next(); reset = 1'b1; settle();
        chk("rst.release_allowin", a_allowin, 1'b1);

        // Fill with trace stalled, then drain in order
        for (int k = 0; k < 4; k++) begin
            next(); beat(32'h1c00_0000 + 32'(4 * k), 1'b1, 5'(k + 1), 32'ha0 + 32'(k), 1'b0, 6'd0, 32'd0, 1'b0);
        end
        next(); beat(32'h1c00_0010, 1'b1, 5'd5, 32'ha4, 1'b0, 6'd0, 32'd0, 1'b0); settle();
        chk("fill.allowin", a_allowin, 1'b0);
        chk("fill.occ", a_occ, 3'd4);
        chk("fill.model_occ", qa.size(), 4);
        next(); ms_to_ws_valid = 1'b0; trace_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) next();
            settle();
            chk("fill.rf_we", a_rf_we, 1'b1);
            chk("fill.pc", a_dpc, 32'h1c00_0000 + 32'(4 * k));
        end
        next(); settle();
        chk("fill.empty", a_occ, 3'd0);

        // Scoreboard
        trace_ready = 1'b0;
        next(); beat(32'h1c00_0100, 1'b1, 5'd5, 32'h55, 1'b0, 6'd0, 32'd0, 1'b0);
        next(); beat(32'h1c00_0104, 1'b1, 5'd0, 32'h66, 1'b0, 6'd0, 32'd0, 1'b0); settle();
        chk("sb.busy", a_busy, 32'h0000_0020);
        chk("sb.model_busy", ea.busy, 32'h0000_0020);
        next(); ms_to_ws_valid = 1'b0; trace_ready = 1'b1; settle();
        chk("sb.we5", a_rf_we, 1'b1);
        chk("sb.waddr5", a_waddr, 5'd5);
        next(); settle();
        chk("sb.we0", a_rf_we, 1'b1);
        chk("sb.waddr0", a_waddr, 5'd0);
        chk("sb.busy_clear", a_busy, 32'd0);

        // Exception flush
        next(); trace_ready = 1'b0;
        beat(32'h1c00_0200, 1'b1, 5'd3, 32'h33, 1'b0, 6'd0, 32'd0, 1'b0);
        next(); beat(32'h1c00_0204, 1'b1, 5'd4, 32'h44, 1'b1, 6'h09, 32'h1234, 1'b0);
        next(); beat(32'h1c00_0208, 1'b1, 5'd6, 32'h66, 1'b0, 6'd0, 32'd0, 1'b0);
        next(); ms_to_ws_valid = 1'b0; trace_ready = 1'b1; settle();
        chk("ex.a_we", a_rf_we, 1'b1);
        chk("ex.a_waddr", a_waddr, 5'd3);
        next(); beat(32'h1c00_020c, 1'b1, 5'd7, 32'h77, 1'b0, 6'd0, 32'd0, 1'b0); settle();
        chk("ex.wb_ex", a_ex, 1'b1);
        chk("ex.ecode", a_ec, 6'h09);
        chk("ex.vaddr", a_va, 32'h1234);
        chk("ex.rf_we", a_rf_we, 1'b0);
        next(); settle();
        chk("ex.occ0", a_occ, 3'd0);
        chk("ex.hold", a_allowin, 1'b0);
        next(); ms_to_ws_valid = 1'b0; settle();
        chk("ex.reopen", a_allowin, 1'b1);

        // ertn, then ex+ertn priority
        next(); beat(32'h1c00_0300, 1'b1, 5'd7, 32'h70, 1'b0, 6'd0, 32'd0, 1'b1);
        next(); ms_to_ws_valid = 1'b0; settle();
        chk("ertn.wb_ertn", a_ertn, 1'b1);
        chk("ertn.wb_ex", a_ex, 1'b0);
        chk("ertn.rf_we", a_rf_we, 1'b0);
        next(); beat(32'h1c00_0304, 1'b1, 5'd8, 32'h80, 1'b1, 6'h0c, 32'h88, 1'b1); settle();
        chk("ertn.hold", a_allowin, 1'b0);
        next();
        next(); ms_to_ws_valid = 1'b0; settle();
        chk("prio.wb_ex", a_ex, 1'b1);
        chk("prio.wb_ertn", a_ertn, 1'b0);
        chk("prio.ecode", a_ec, 6'h0c);
        repeat (6) next();

        // Back-to-back push/pop across pointer wrap (A: trace ready, B: trace ignored)
        for (int p = 0; p < 2; p++) begin
            trace_ready = (p == 0);
            for (int i = 0; i < 20; i++) begin
                next(); beat(32'h1c00_1000 + 32'(4 * i), 1'b1, 5'(i % 31 + 1), 32'(i), 1'b0, 6'd0, 32'd0, 1'b0);
                settle();
                if (i > 0) begin
                    chk("pp.b_occ", b_occ, 3'd1);
                    chk("pp.b_pc", b_dpc, 32'h1c00_1000 + 32'(4 * (i - 1)));
                    if (p == 0) begin
                        chk("pp.a_occ", a_occ, 3'd1);
                        chk("pp.a_pc", a_dpc, 32'h1c00_1000 + 32'(4 * (i - 1)));
                    end
                end
            end
            next(); ms_to_ws_valid = 1'b0; trace_ready = 1'b1;
            repeat (6) next();
        end

        // Asynchronous reset with three entries queued
        trace_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next(); beat(32'h1c00_2000 + 32'(4 * k), 1'b1, 5'(k + 9), 32'(k), 1'b0, 6'd0, 32'd0, 1'b0);
        end
        next(); ms_to_ws_valid = 1'b0; settle();
        chk("ar.occ3", a_occ, 3'd3);
        reset = 1'b0; trace_ready = 1'b1; #1;
        chk("ar.occ", a_occ, 3'd0);
        chk("ar.allowin", a_allowin, 1'b0);
        chk("ar.busy", a_busy, 32'd0);
        chk("ar.rf_we", a_rf_we, 1'b0);
        chk("ar.dpc", a_dpc, 32'd0);
        next(); reset = 1'b1; settle();
        chk("ar.allowin_after", a_allowin, 1'b1);
        chk("ar.no_retire", a_rf_we, 1'b0);
        chk("ar.occ_after", a_occ, 3'd0);

        // Randomised traffic; a beat is replaced only once A has taken it
        for (int n = 0; n < 500; n++) begin
            next();
            if (push_a || !ms_to_ws_valid)
                beat($urandom, 1'($urandom), 5'($urandom), $urandom, ($urandom_range(0, 11) == 0),
                     6'($urandom), $urandom, ($urandom_range(0, 11) == 0));
            ms_to_ws_valid = ($urandom_range(0, 3) != 0);
            trace_ready = ($urandom_range(0, 2) != 0);
        end
        next(); ms_to_ws_valid = 1'b0; trace_ready = 1'b1;
        repeat (8) next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
